// File: rtl/pllchk_pkg.sv
// Shared types and helpers for the PLLE2 divided-clock frequency checker.
package pllchk_pkg;

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, EVAL, REPORT} state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int BOUND_VEC_W = 1024;

  // Bound vectors are zero-extended to BOUND_VEC_W so one function serves any N_CH/CNT_W.
  function automatic logic [31:0] bound_field(input logic [BOUND_VEC_W-1:0] vec,
                                              input int idx, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return 32'(vec >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/pllchk_edge_cnt.sv
// One monitored tap: 2-flop synchroniser, rising-edge detect and saturating edge counter.
module pllchk_edge_cnt
  import pllchk_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tap,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic sync1, sync2, prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= tap;
      sync2 <= sync1;
      prev  <= sync2;
      if (clr)
        cnt <= '0;
      else if (en && sync2 && !prev && cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/plle2_cnt_checker.sv
// Gated per-channel edge counter with bound check for the PLLE2 CLKOUT taps.
// Define PLLCHK_RAW_COUNT_EN to latch the raw counts onto O_RAW; otherwise O_RAW is tied to 0.
module plle2_cnt_checker
  import pllchk_pkg::*;
#(
  parameter int                    N_CH          = 6,
  parameter int                    CNT_W         = DEF_CNT_W,
  parameter int                    GATE_CYCLES   = 200_000_000,
  parameter int                    SETTLE_CYCLES = 1_000_000,
  parameter logic [N_CH*CNT_W-1:0] EXP_LO        = '0,
  parameter logic [N_CH*CNT_W-1:0] EXP_HI        = '1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [N_CH-1:0]       I_CNT,
  input  logic                  I_LOCKED,
  input  logic                  I_START,
  input  logic                  I_CONT,
  output logic                  O_BUSY,
  output logic                  O_VALID,
  output logic [N_CH-1:0]       O_PASS,
  output logic                  O_ERR_LOCK,
  output logic [N_CH*CNT_W-1:0] O_RAW
);

  localparam int GATE_W   = $clog2(GATE_CYCLES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [BOUND_VEC_W-1:0] LO_EXT = BOUND_VEC_W'(EXP_LO);
  localparam logic [BOUND_VEC_W-1:0] HI_EXT = BOUND_VEC_W'(EXP_HI);

  state_t              state;
  logic [GATE_W-1:0]   gate_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                lock_s1, lock_s2;
  logic [CNT_W-1:0]    cnt [N_CH];
  logic [N_CH-1:0]     pass_next;
  logic                cnt_clr, cnt_en;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      lock_s1 <= I_LOCKED;
      lock_s2 <= lock_s1;
    end
  end

  // MEASURE is only ever entered from SETTLE, so clearing there gives a clean window start.
  assign cnt_clr = (state == SETTLE);
  assign cnt_en  = (state == MEASURE);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pllchk_edge_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk  (CLK),
      .rst_n(RST_N),
      .tap  (I_CNT[g]),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .cnt  (cnt[g])
    );
  end

  always_comb begin
    pass_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      pass_next[i] = (32'(cnt[i]) >= bound_field(LO_EXT, i, CNT_W)) &&
                     (32'(cnt[i]) <= bound_field(HI_EXT, i, CNT_W));
    end
  end

  // A nonzero settle count means lock was high last cycle, so a low lock now is a real loss.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      settle_cnt <= '0;
      O_BUSY     <= 1'b0;
      O_VALID    <= 1'b0;
      O_PASS     <= '0;
      O_ERR_LOCK <= 1'b0;
    end else begin
      O_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (I_START) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            O_BUSY     <= 1'b1;
            O_ERR_LOCK <= 1'b0;
          end
        end
        SETTLE: begin
          if (!lock_s2) begin
            if (settle_cnt != '0) O_ERR_LOCK <= 1'b1;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
            state    <= MEASURE;
            gate_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (!lock_s2) begin
            O_ERR_LOCK <= 1'b1;
            state      <= SETTLE;
            settle_cnt <= '0;
          end else if (gate_cnt == GATE_W'(GATE_CYCLES - 1)) begin
            state <= EVAL;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        EVAL: begin
          O_PASS  <= pass_next;
          O_VALID <= 1'b1;
          state   <= REPORT;
        end
        REPORT: begin
          settle_cnt <= '0;
          if (I_CONT) begin
            state <= SETTLE;
          end else begin
            state  <= IDLE;
            O_BUSY <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PLLCHK_RAW_COUNT_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      O_RAW <= '0;
    end else if (state == EVAL) begin
      for (int i = 0; i < N_CH; i++) O_RAW[i*CNT_W +: CNT_W] <= cnt[i];
    end
  end
`else
  assign O_RAW = '0;
`endif

endmodule

// File: tb/tb_plle2_cnt_checker.sv
// Self-checking bench for plle2_cnt_checker: randomised tap bursts against an edge-count model,
// plus lock loss, restart, mid-window reset, continuous mode and a 4-bit saturating instance.
module tb_plle2_cnt_checker;

  localparam int N_CH   = 6;
  localparam int G      = 1000;
  localparam int S      = 10;
  localparam int LO     = 48;
  localparam int HI     = 52;
  localparam int SAT    = 15;
  localparam int PERIOD = S + G + 2;

  logic clk = 1'b0;
  logic rst_n, locked, start, cont;
  logic [N_CH-1:0] taps, burst;
  logic busy, valid, err, busy4, valid4, err4;
  logic [N_CH-1:0] pass, pass4;
  logic [N_CH*16-1:0] raw;
  logic [N_CH*4-1:0] raw4;

  int n_tests = 0;
  int n_fail  = 0;
  int n_edge [N_CH];
  int per [N_CH];
  logic free_en = 1'b0;
  int free_cnt = 0;

  int vc;
  logic [N_CH-1:0] cap_pass, cap_pass4;
  logic cap_busy, cap_err, cap_err4, cap_valid4;
  logic [N_CH*16-1:0] cap_raw;
  logic [N_CH*4-1:0] cap_raw4;
  logic err_early, err_mid, busy_mid;

  always #5 clk = ~clk;

  // Channel 0 can run as a free-running period-20 tap, like a real PLL output.
  always @(negedge clk) free_cnt <= (free_cnt == 19) ? 0 : free_cnt + 1;
  assign taps = {burst[N_CH-1:1], free_en ? (free_cnt < 10) : burst[0]};

  plle2_cnt_checker #(
    .N_CH(N_CH), .CNT_W(16), .GATE_CYCLES(G), .SETTLE_CYCLES(S),
    .EXP_LO({N_CH{16'd48}}), .EXP_HI({N_CH{16'd52}})
  ) dut (
    .CLK(clk), .RST_N(rst_n), .I_CNT(taps), .I_LOCKED(locked), .I_START(start),
    .I_CONT(cont), .O_BUSY(busy), .O_VALID(valid), .O_PASS(pass),
    .O_ERR_LOCK(err), .O_RAW(raw)
  );

  plle2_cnt_checker #(
    .N_CH(N_CH), .CNT_W(4), .GATE_CYCLES(G), .SETTLE_CYCLES(S),
    .EXP_LO({N_CH{4'd15}}), .EXP_HI({N_CH{4'd15}})
  ) dut4 (
    .CLK(clk), .RST_N(rst_n), .I_CNT(taps), .I_LOCKED(locked), .I_START(start),
    .I_CONT(cont), .O_BUSY(busy4), .O_VALID(valid4), .O_PASS(pass4),
    .O_ERR_LOCK(err4), .O_RAW(raw4)
  );

  // Burst of n_edge[i] pulses with period per[i], starting 100 cycles after START and
  // ending well before the window closes, so every edge is counted exactly once.
  function automatic logic [N_CH-1:0] burst_at(input int c);
    logic [N_CH-1:0] b;
    int off;
    b = '0;
    off = c - 100;
    for (int i = 0; i < N_CH; i++)
      if (off >= 0 && per[i] > 0 && (off / per[i]) < n_edge[i] && (off % per[i]) < per[i] / 2)
        b[i] = 1'b1;
    return b;
  endfunction

  task automatic clear_edges();
    for (int i = 0; i < N_CH; i++) begin
      n_edge[i] = 0;
      per[i] = 0;
    end
  endtask

  task automatic pick_edges(input int fixed3, input int fixed5);
    clear_edges();
    for (int i = 1; i < N_CH; i++) n_edge[i] = 44 + int'($urandom_range(0, 12));
    if (fixed3 >= 0) n_edge[3] = fixed3;
    if (fixed5 >= 0) n_edge[5] = fixed5;
    for (int i = 1; i < N_CH; i++)
      if (n_edge[i] > 0) per[i] = 6 + int'($urandom_range(0, 780 / n_edge[i] - 6));
  endtask

  task automatic run_measure(input int budget, input int drop_at, input int relock_at,
                             input int restart_at);
    vc = -1;
    cap_pass = 'x; cap_pass4 = 'x; cap_busy = 'x; cap_err = 'x; cap_err4 = 'x;
    cap_valid4 = 'x; cap_raw = 'x; cap_raw4 = 'x;
    err_early = 1'bx; err_mid = 1'bx; busy_mid = 1'bx;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      burst = burst_at(c);
      if (c == drop_at) locked = 1'b0;
      if (c == relock_at) locked = 1'b1;
      start = (c == restart_at);
      if (c == 3) err_early = err;
      if (c == drop_at + 15) err_mid = err;
      if (c == 500) busy_mid = busy;
      if (valid) begin
        vc = c;
        cap_pass = pass; cap_pass4 = pass4; cap_busy = busy; cap_err = err; cap_err4 = err4;
        cap_valid4 = valid4; cap_raw = raw; cap_raw4 = raw4;
        break;
      end
      @(negedge clk);
    end
    burst = '0; locked = 1'b1; start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags: got busy=%b valid=%b err=%b expected 0 0 0", busy, valid, err);
    end
    n_tests++;
    if (pass !== '0 || raw !== '0) begin
      n_fail++; $display("[TB] FAIL reset_data: got pass=%b raw=%h expected 0", pass, raw);
    end
    n_tests++;
    if (busy4 !== 1'b0 || pass4 !== '0 || raw4 !== '0) begin
      n_fail++; $display("[TB] FAIL reset_dut4: got busy=%b pass=%b raw=%h expected 0", busy4, pass4, raw4);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL idle_after_reset: got busy=%b valid=%b expected 0 0", busy, valid);
    end
  endtask

  task automatic test_windows();
    logic [N_CH-1:0] exp_p, exp_p4;
    int f;
    for (int it = 0; it < 3; it++) begin
      free_en = 1'b1;
      pick_edges(it == 0 ? 0 : (it == 1 ? 52 : 53), it == 1 ? 30 : -1);
      run_measure(1300, 0, 0, 0);
      exp_p = N_CH'(1);
      exp_p4 = N_CH'(1);
      for (int i = 1; i < N_CH; i++) begin
        exp_p[i]  = (n_edge[i] >= LO && n_edge[i] <= HI);
        exp_p4[i] = (n_edge[i] >= SAT);
      end
      // Lock held throughout: anywhere from S+G+1 up to the quoted 2+S+G+2 is acceptable.
      n_tests++;
      if (vc < S + G + 1 || vc > S + G + 4) begin
        n_fail++; $display("[TB] FAIL win%0d_latency: got %0d expected %0d..%0d", it, vc, S + G + 1, S + G + 4);
      end
      n_tests++;
      if (cap_pass !== exp_p) begin
        n_fail++; $display("[TB] FAIL win%0d_pass: got %b expected %b", it, cap_pass, exp_p);
      end
      n_tests++;
      if (cap_pass4 !== exp_p4 || cap_valid4 !== 1'b1) begin
        n_fail++; $display("[TB] FAIL win%0d_sat_pass: got %b valid=%b expected %b valid=1", it, cap_pass4, cap_valid4, exp_p4);
      end
      n_tests++;
      if (cap_busy !== 1'b1 || cap_err !== 1'b0 || busy_mid !== 1'b1) begin
        n_fail++; $display("[TB] FAIL win%0d_status: got busy=%b mid=%b err=%b expected 1 1 0", it, cap_busy, busy_mid, cap_err);
      end
`ifdef PLLCHK_RAW_COUNT_EN
      for (int i = 0; i < N_CH; i++) begin
        f = int'(cap_raw[i*16 +: 16]);
        n_tests++;
        if (i == 0 ? (f < 49 || f > 51) : (f != n_edge[i])) begin
          n_fail++; $display("[TB] FAIL win%0d_raw%0d: got %0d expected %0d", it, i, f, i == 0 ? 50 : n_edge[i]);
        end
        f = int'(cap_raw4[i*4 +: 4]);
        n_tests++;
        if (f != (i == 0 ? SAT : (n_edge[i] > SAT ? SAT : n_edge[i]))) begin
          n_fail++; $display("[TB] FAIL win%0d_raw4_%0d: got %0d expected saturated count", it, i, f);
        end
      end
`else
      f = 0;
      n_tests++;
      if (cap_raw !== '0 || cap_raw4 !== '0) begin
        n_fail++; $display("[TB] FAIL win%0d_raw_tied: got %h/%h expected 0 (%0d)", it, cap_raw, cap_raw4, f);
      end
`endif
      @(negedge clk);
      n_tests++;
      if (valid !== 1'b0 || busy !== 1'b0 || pass !== exp_p) begin
        n_fail++; $display("[TB] FAIL win%0d_post: got valid=%b busy=%b pass=%b expected 0 0 %b", it, valid, busy, pass, exp_p);
      end
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_lock_loss();
    free_en = 1'b1;
    clear_edges();
    run_measure(1800, 510, 530, 0);
    n_tests++;
    if (err_mid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL lock_err_set: got %b expected 1", err_mid);
    end
    n_tests++;
    if (vc < 530 + S + G || vc > 530 + S + G + 6) begin
      n_fail++; $display("[TB] FAIL lock_rerun_latency: got %0d expected %0d..%0d", vc, 530 + S + G, 530 + S + G + 6);
    end
    n_tests++;
    if (cap_err !== 1'b1 || cap_err4 !== 1'b1) begin
      n_fail++; $display("[TB] FAIL lock_err_sticky: got %b/%b expected 1/1", cap_err, cap_err4);
    end
    n_tests++;
    if (cap_pass !== N_CH'(1) || cap_pass4 !== N_CH'(1)) begin
      n_fail++; $display("[TB] FAIL lock_pass: got %b/%b expected 000001", cap_pass, cap_pass4);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_restart_ignored();
    logic [N_CH-1:0] exp_p;
    free_en = 1'b1;
    pick_edges(-1, -1);
    run_measure(1300, 0, 0, 200);
    exp_p = N_CH'(1);
    for (int i = 1; i < N_CH; i++) exp_p[i] = (n_edge[i] >= LO && n_edge[i] <= HI);
    n_tests++;
    if (err_early !== 1'b0) begin
      n_fail++; $display("[TB] FAIL start_clears_err: got %b expected 0", err_early);
    end
    n_tests++;
    if (vc < S + G + 1 || vc > S + G + 4) begin
      n_fail++; $display("[TB] FAIL restart_latency: got %0d expected %0d..%0d", vc, S + G + 1, S + G + 4);
    end
    n_tests++;
    if (cap_pass !== exp_p) begin
      n_fail++; $display("[TB] FAIL restart_pass: got %b expected %b", cap_pass, exp_p);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic err_pre;
    int seen;
    free_en = 1'b1;
    clear_edges();
    err_pre = 1'bx;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 470; c++) begin
      if (c == 150) locked = 1'b0;
      if (c == 160) locked = 1'b1;
      if (c == 460) err_pre = err;
      @(negedge clk);
    end
    n_tests++;
    if (err_pre !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL pre_reset: got err=%b busy=%b expected 1 1", err_pre, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || valid !== 1'b0 || err !== 1'b0 || pass !== '0 || raw !== '0) begin
      n_fail++; $display("[TB] FAIL mid_reset: got busy=%b valid=%b err=%b pass=%b expected all 0", busy, valid, err, pass);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if (valid === 1'b1 || busy === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("[TB] FAIL no_report_after_reset: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_continuous();
    int v [3];
    int nv;
    free_en = 1'b1;
    clear_edges();
    for (int i = 0; i < 3; i++) v[i] = -99999;
    nv = 0;
    cont = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 3 * PERIOD + 200 && nv < 3; c++) begin
      if (valid === 1'b1) begin
        v[nv] = c;
        n_tests++;
        if (pass !== N_CH'(1)) begin
          n_fail++; $display("[TB] FAIL cont_pass%0d: got %b expected 000001", nv, pass);
        end
        nv++;
      end
      if (nv == 2 && c == v[1] + 100) cont = 1'b0;
      @(negedge clk);
    end
    cont = 1'b0;
    n_tests++;
    if (nv != 3) begin
      n_fail++; $display("[TB] FAIL cont_reports: got %0d expected 3", nv);
    end
    n_tests++;
    if (v[1] - v[0] != PERIOD || v[2] - v[1] != PERIOD) begin
      n_fail++; $display("[TB] FAIL cont_period: got %0d,%0d expected %0d", v[1] - v[0], v[2] - v[1], PERIOD);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL cont_busy_drop: got %b expected 0", busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; locked = 1'b1; start = 1'b0; cont = 1'b0; burst = '0;
    clear_edges();
    test_reset();
    test_windows();
    test_lock_loss();
    test_restart_ignored();
    test_reset_mid();
    test_continuous();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
